// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command-issue stage: operand/opcode/result
// widths, the buffered command record, result-flag bit positions and the
// observational sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W      = 3;
    localparam int OPND_W    = 4;
    localparam int RES_W     = 8;
    localparam int FLAG_W    = 5;

    // The command record carries the widest tag any instance may use; an
    // instance keeps only the low TAG_W bits meaningful.
    localparam int TAG_MAX_W = 8;

    // Bit positions within res_flags / sticky_flags.
    localparam int FLAG_CARRY  = 0;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_SIGN   = 3;
    localparam int FLAG_OVF    = 4;

    // Opcode that selects the ALU default case when nothing is queued.
    localparam logic [OP_W-1:0] OP_IDLE = 3'b111;

    typedef struct packed {
        logic [OPND_W-1:0]    a;
        logic [OPND_W-1:0]    b;
        logic [OP_W-1:0]      op;
        logic [TAG_MAX_W-1:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO of alu_cmd_t records with a combinational head view so
// the ALU can be driven from the oldest entry in the same cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request / record (ignored when full)
//   pop                 remove head (ignored when empty)
//   head                oldest record
//   full, empty, count  occupancy status
// ---------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  alu_cmd_t                 push_data,
    input  logic                     pop,
    output alu_cmd_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    alu_cmd_t         mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Command-issue stage in front of the combinational 4-bit ALU. Commands are
// queued in alu_cmd_fifo, the head drives the ALU inputs, and the ALU result
// plus flags are captured into a valid/ready result register tagged with a
// per-command sequence number.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_a/b/op    command input handshake
//   alu_a, alu_b, alu_opcode           drive to the ALU
//   alu_out, alu_* flags               combinational ALU response
//   res_valid/res_ready                result handshake
//   res_data, res_flags, res_tag       registered result
//   cmd_count                          FIFO occupancy
//   flags_clr, sticky_flags            only with ALU_STICKY_FLAGS_EN defined
// Optional feature macro: ALU_STICKY_FLAGS_EN (OR-accumulated flag history).
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPND_W-1:0]        cmd_a,
    input  logic [OPND_W-1:0]        cmd_b,
    input  logic [OP_W-1:0]          cmd_op,
    output logic [OPND_W-1:0]        alu_a,
    output logic [OPND_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_opcode,
    input  logic [RES_W-1:0]         alu_out,
    input  logic                     alu_carry_borrow,
    input  logic                     alu_zero,
    input  logic                     alu_parity,
    input  logic                     alu_sign,
    input  logic                     alu_overflow,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [FLAG_W-1:0]        res_flags,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   cmd_count
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic                     flags_clr,
    output logic [FLAG_W-1:0]        sticky_flags
`endif
);

    alu_cmd_t          push_cmd;
    alu_cmd_t          head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              issue;
    logic [FLAG_W-1:0] new_flags;

    logic [TAG_W-1:0]  tag_ctr_reg;
    logic              res_valid_reg;
    logic [RES_W-1:0]  res_data_reg;
    logic [FLAG_W-1:0] res_flags_reg;
    logic [TAG_W-1:0]  res_tag_reg;
    seq_state_t        state_reg;

    // cmd_ready depends only on stored occupancy, so a full FIFO refuses a
    // push even in a cycle where the head is being issued.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign issue     = !fifo_empty && (!res_valid_reg || res_ready);

    assign push_cmd.a   = cmd_a;
    assign push_cmd.b   = cmd_b;
    assign push_cmd.op  = cmd_op;
    assign push_cmd.tag = TAG_MAX_W'(tag_ctr_reg);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (issue),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    // Upper tag bits of the shared record are never populated here.
    logic unused_head_tag;
    generate
        if (TAG_W < TAG_MAX_W) begin : g_tag_trim
            assign unused_head_tag = |head_cmd.tag[TAG_MAX_W-1:TAG_W];
        end else begin : g_tag_full
            assign unused_head_tag = 1'b0;
        end
    endgenerate

    // An empty FIFO parks the ALU on its default case.
    assign alu_a      = fifo_empty ? '0      : head_cmd.a;
    assign alu_b      = fifo_empty ? '0      : head_cmd.b;
    assign alu_opcode = fifo_empty ? OP_IDLE : head_cmd.op;

    always_comb begin
        new_flags              = '0;
        new_flags[FLAG_CARRY]  = alu_carry_borrow;
        new_flags[FLAG_ZERO]   = alu_zero;
        new_flags[FLAG_PARITY] = alu_parity;
        new_flags[FLAG_SIGN]   = alu_sign;
        new_flags[FLAG_OVF]    = alu_overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_ctr_reg <= '0;
        end else if (push) begin
            tag_ctr_reg <= tag_ctr_reg + TAG_W'(1);
        end
    end

    // Issue takes priority over drain so a drain+issue cycle reloads the
    // register and keeps res_valid high for back-to-back results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_flags_reg <= '0;
            res_tag_reg   <= '0;
        end else if (issue) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= alu_out;
            res_flags_reg <= new_flags;
            res_tag_reg   <= head_cmd.tag[TAG_W-1:0];
        end else if (res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_flags = res_flags_reg;
    assign res_tag   = res_tag_reg;

    // Observational state only; nothing in the datapath reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push) state_reg <= RUN;
                end
                RUN: begin
                    if (res_valid_reg && !res_ready && !fifo_empty) begin
                        state_reg <= STALL;
                    end else if (fifo_empty && !push &&
                                 (!res_valid_reg || res_ready)) begin
                        state_reg <= IDLE;
                    end
                end
                STALL: begin
                    if (res_ready) state_reg <= RUN;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [FLAG_W-1:0] sticky_flags_reg;

    // A clear coinciding with an issue keeps only the newly issued flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags_reg <= '0;
        end else if (flags_clr) begin
            sticky_flags_reg <= issue ? new_flags : '0;
        end else if (issue) begin
            sticky_flags_reg <= sticky_flags_reg | new_flags;
        end
    end

    assign sticky_flags = sticky_flags_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Scoreboard bench: a stand-in ALU answers the DUT's ALU drive, accepted
// commands push their expected result into a queue, and a monitor pops and
// compares every result handshake. Directed phases cover reset, latency,
// zero flag, stall/full, tag wrap and mid-stream reset; a random phase
// follows. Define ALU_STICKY_FLAGS_EN to exercise the sticky flags.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       alu_carry_borrow, alu_zero, alu_parity, alu_sign, alu_overflow;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic [4:0] res_flags;
    logic [TAG_W-1:0] res_tag;
    logic [$clog2(DEPTH):0] cmd_count;
`ifdef ALU_STICKY_FLAGS_EN
    logic       flags_clr;
    logic [4:0] sticky_flags;
`endif

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_a            (cmd_a),
        .cmd_b            (cmd_b),
        .cmd_op           (cmd_op),
        .alu_a            (alu_a),
        .alu_b            (alu_b),
        .alu_opcode       (alu_opcode),
        .alu_out          (alu_out),
        .alu_carry_borrow (alu_carry_borrow),
        .alu_zero         (alu_zero),
        .alu_parity       (alu_parity),
        .alu_sign         (alu_sign),
        .alu_overflow     (alu_overflow),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_flags        (res_flags),
        .res_tag          (res_tag),
        .cmd_count        (cmd_count)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .flags_clr        (flags_clr),
        .sticky_flags     (sticky_flags)
`endif
    );

    // Stand-in ALU: returns {overflow, sign, parity, zero, carry, out}.
    function automatic logic [12:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] op);
        logic [7:0] o;
        logic [4:0] w;
        logic       c, v;
        o = 8'h00; c = 1'b0; v = 1'b0; w = 5'h00;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                o = {3'b000, w};
                c = w[4];
                v = (a[3] == b[3]) && (w[3] != a[3]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                o = {4'h0, w[3:0]};
                c = w[4];
                v = (a[3] != b[3]) && (w[3] != a[3]);
            end
            3'd2: o = {4'h0, a & b};
            3'd3: o = {4'h0, a | b};
            3'd4: o = {4'h0, a ^ b};
            3'd5: o = 8'(a) * 8'(b);
            3'd6: o = 8'(a) << b[1:0];
            default: o = 8'h00;
        endcase
        return {v, o[7], ^o, (o == 8'h00), c, o};
    endfunction

    assign {alu_overflow, alu_sign, alu_parity, alu_zero, alu_carry_borrow, alu_out} =
        alu_ref(alu_a, alu_b, alu_opcode);

    typedef struct {
        logic [7:0]       data;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   tag_model = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Scoreboard input: every accepted command yields one expected result.
    always @(negedge clk) begin : sb_push
        logic [12:0] r;
        if (rst_n && cmd_valid && cmd_ready) begin
            r = alu_ref(cmd_a, cmd_b, cmd_op);
            exp_q.push_back('{data: r[7:0], flags: r[12:8], tag: TAG_W'(tag_model)});
            tag_model = (tag_model + 1) % (1 << TAG_W);
        end
    end

    // Monitor: compare each result handshake against the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_result: got tag %0d data %0h, required no result",
                         res_tag, res_data);
            end else begin
                e = exp_q.pop_front();
                if (res_data === e.data && res_flags === e.flags && res_tag === e.tag) begin
                    passes++;
                    $display("result tag=%0d data=%0h flags=%b ok", res_tag, res_data, res_flags);
                end else begin
                    $display("FAIL result: got data=%0h flags=%b tag=%0d, required data=%0h flags=%b tag=%0d",
                             res_data, res_flags, res_tag, e.data, e.flags, e.tag);
                end
            end
        end
    end

    // Held results must not change while back-pressured.
    logic        prev_stall = 1'b0;
    logic [16:0] snap = '0;
    always @(negedge clk) begin
        if (rst_n && res_valid && !res_ready) begin
            if (prev_stall) chk("stall_stable", 32'({res_data, res_flags, res_tag}), 32'(snap));
            snap       = {res_data, res_flags, res_tag};
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int   n;
        logic ok;
        n = 0; ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL push_timeout: got cmd_ready=0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic check_reset_outputs(input string tagname);
        chk({tagname, "_res_valid"},  32'(res_valid),  32'(0));
        chk({tagname, "_cmd_ready"},  32'(cmd_ready),  32'(1));
        chk({tagname, "_cmd_count"},  32'(cmd_count),  32'(0));
        chk({tagname, "_alu_opcode"}, 32'(alu_opcode), 32'(7));
        chk({tagname, "_alu_ab"},     32'({alu_a, alu_b}), 32'(0));
        chk({tagname, "_res_regs"},   32'({res_data, res_flags, res_tag}), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;
`ifdef ALU_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // Latency and basic results.
        res_ready = 1'b1;
        push_cmd(4'd7, 4'd5, 3'd0);
        chk("latency_not_early", 32'(res_valid), 32'(0));
        chk("head_drive", 32'({alu_a, alu_b, alu_opcode}), 32'({4'd7, 4'd5, 3'd0}));
        step(1);
        chk("latency_valid", 32'(res_valid), 32'(1));
        chk("add_data", 32'(res_data), 32'(12));
        chk("add_tag", 32'(res_tag), 32'(0));
        push_cmd(4'd7, 4'd5, 3'd1);
        step(1);
        chk("sub_data", 32'(res_data), 32'(2));
        chk("sub_tag", 32'(res_tag), 32'(1));
        push_cmd(4'd4, 4'd4, 3'd1);
        step(1);
        chk("zero_data", 32'(res_data), 32'(0));
        chk("zero_flag", 32'(res_flags[FLAG_ZERO]), 32'(1));
        step(2);

        // Back-pressure: one held result plus a full FIFO.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(4'(i + 1), 4'd2, 3'd0);
        chk("full_ready", 32'(cmd_ready), 32'(0));
        chk("full_count", 32'(cmd_count), 32'(4));
        chk("stall_state", 32'(dut.state_reg), 32'(STALL));
        chk("stall_head_tag", 32'(res_tag), 32'(3));
        chk("stall_head_data", 32'(res_data), 32'(3));
        cmd_a = 4'hf; cmd_b = 4'hf; cmd_op = 3'd0; cmd_valid = 1'b1;
        step(3);
        cmd_valid = 1'b0;
        chk("full_refuse_count", 32'(cmd_count), 32'(4));
        chk("full_refuse_ready", 32'(cmd_ready), 32'(0));
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_valid", 32'(res_valid), 32'(1));
            chk("b2b_tag", 32'(res_tag), 32'(3 + i));
            step(1);
        end
        chk("b2b_done", 32'(res_valid), 32'(0));

        // Tag wrap, then reset with work pending.
        for (int i = 0; i < 17; i++)
            push_cmd(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(4'(i + 9), 4'd1, 3'd1);
        rst_n = 1'b0;
        exp_q.delete();
        tag_model = 0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk) rst_n = 1'b1;
        step(1);
        res_ready = 1'b1;
        push_cmd(4'd3, 4'd3, 3'd0);
        step(1);
        chk("post_reset_tag", 32'(res_tag), 32'(0));
        chk("post_reset_data", 32'(res_data), 32'(6));
        step(2);

`ifdef ALU_STICKY_FLAGS_EN
        flags_clr = 1'b1;
        step(1);
        flags_clr = 1'b0;
        push_cmd(4'd4, 4'd4, 3'd1);
        push_cmd(4'd7, 4'd5, 3'd0);
        step(2);
        chk("sticky_zero_kept", 32'(sticky_flags[FLAG_ZERO]), 32'(1));
        flags_clr = 1'b1;
        step(1);
        flags_clr = 1'b0;
        chk("sticky_cleared", 32'(sticky_flags), 32'(0));
`endif

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_op    = 3'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) step(1);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
